// File: rtl/musica_pkg.sv
// Shared constants for the tone generator: base note frequencies, FSM state type and the
// elaboration-time half-period calculation.
package musica_pkg;

  localparam int unsigned NUM_NOTAS_BASE = 7;

  // Element [i] is base note i (C6 .. B6, in Hz).
  localparam logic [NUM_NOTAS_BASE-1:0][15:0] FREQ_NOTAS = {
    16'd1975, 16'd1760, 16'd1567, 16'd1396, 16'd1318, 16'd1174, 16'd1046
  };

  typedef enum logic [0:0] {IDLE, PLAY} estado_t;

  // Half-period in clock cycles for key idx; each group of seven keys is one octave higher.
  function automatic int unsigned half_period(int unsigned clk_freq, int unsigned idx);
    int unsigned f;
    f = 32'(FREQ_NOTAS[3'(idx % NUM_NOTAS_BASE)]);
    return (clk_freq / (2 * f)) >> (idx / NUM_NOTAS_BASE);
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Per-key two-flop synchroniser followed by a debouncer that accepts a new level only after
// it has been stable for DEBOUNCE consecutive cycles.
module antirrebote #(
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic entrada,
  output logic salida
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          sync1_q, sync2_q, salida_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      salida_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= entrada;
      sync2_q <= sync1_q;
      // Any cycle where the synchronised level agrees with the output restarts the count.
      if (sync2_q != salida_q) begin
        if (cnt_q == CW'(DEBOUNCE - 1)) begin
          salida_q <= sync2_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign salida = salida_q;

endmodule

// File: rtl/generador_tonos.sv
// Keypad-to-square-wave tone generator: debounced keys, lowest-index priority, glitch-free
// note changes at full-period boundaries. Optional OCTAVE_SHIFT_EN adds the bajar_octava input.
module generador_tonos
  import musica_pkg::*;
#(
  parameter  int unsigned NUM_TECLAS = 7,
  parameter  int unsigned CLK_FREQ   = 50_000_000,
  parameter  int unsigned DEBOUNCE   = 16,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned IDX_W      = (NUM_TECLAS > 1) ? $clog2(NUM_TECLAS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_TECLAS-1:0] teclas,
  output logic                  clk_out,
  output logic                  activo,
  output logic [IDX_W-1:0]      nota
`ifdef OCTAVE_SHIFT_EN
  ,
  input  logic                  bajar_octava
`endif
);

  localparam int unsigned TBL_N = 2 ** IDX_W;
`ifdef OCTAVE_SHIFT_EN
  localparam longint unsigned MULT = 2;
`else
  localparam longint unsigned MULT = 1;
`endif

  logic [NUM_TECLAS-1:0] teclas_deb;
  logic [CNT_W-1:0]      half_tbl [TBL_N];

  for (genvar g = 0; g < NUM_TECLAS; g++) begin : g_tecla
    antirrebote #(
      .DEBOUNCE (DEBOUNCE)
    ) u_antirrebote (
      .clk     (clk),
      .reset   (reset),
      .entrada (teclas[g]),
      .salida  (teclas_deb[g])
    );
  end

  // Table padded to a power of two so the index never falls outside it.
  for (genvar g = 0; g < TBL_N; g++) begin : g_tabla
    if (g < NUM_TECLAS) begin : g_nota
      localparam int unsigned H = half_period(CLK_FREQ, g);
      if (H == 0 || (longint'(H) * MULT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_err
        $error("generador_tonos: half-period of key %0d does not fit CNT_W", g);
      end
      assign half_tbl[g] = CNT_W'(H);
    end else begin : g_relleno
      assign half_tbl[g] = CNT_W'(1);
    end
  end

  logic             req_valid;
  logic [IDX_W-1:0] req_idx;

  always_comb begin
    req_idx = '0;
    for (int i = NUM_TECLAS - 1; i >= 0; i--) begin
      if (teclas_deb[i]) req_idx = IDX_W'(i);
    end
  end

  assign req_valid = |teclas_deb;

  estado_t          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clk_out_q, activo_q;
  logic [IDX_W-1:0] nota_q;
  logic [CNT_W-1:0] half_req, half_cur;
  logic             shift_req;

`ifdef OCTAVE_SHIFT_EN
  logic shift_q;
  assign shift_req = bajar_octava;
  assign half_req  = half_tbl[req_idx] << bajar_octava;
  assign half_cur  = half_tbl[nota_q] << shift_q;
`else
  assign shift_req = 1'b0;
  assign half_req  = half_tbl[req_idx];
  assign half_cur  = half_tbl[nota_q];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      activo_q  <= 1'b0;
      nota_q    <= '0;
`ifdef OCTAVE_SHIFT_EN
      shift_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          clk_out_q <= 1'b0;
          activo_q  <= 1'b0;
          if (req_valid) begin
            nota_q    <= req_idx;
            cnt_q     <= half_req - CNT_W'(1);
            clk_out_q <= 1'b1;
            activo_q  <= 1'b1;
            state_q   <= PLAY;
`ifdef OCTAVE_SHIFT_EN
            shift_q   <= shift_req;
`endif
          end
        end
        PLAY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (clk_out_q) begin
            clk_out_q <= 1'b0;
            cnt_q     <= half_cur - CNT_W'(1);
          end else if (req_valid) begin
            // Full period done: the only point where a new note (or octave) is adopted.
            nota_q    <= req_idx;
            cnt_q     <= half_req - CNT_W'(1);
            clk_out_q <= 1'b1;
`ifdef OCTAVE_SHIFT_EN
            shift_q   <= shift_req;
`endif
          end else begin
            activo_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_shift;
  assign unused_shift = shift_req;

  assign clk_out = clk_out_q;
  assign activo  = activo_q;
  assign nota    = nota_q;

endmodule

// File: tb/tb_generador_tonos.sv
// Bench for generador_tonos: a negedge monitor measures every tone period and checks it
// against a queue of expected {nota, half} records pushed by the stimulus.
module tb_generador_tonos;

  localparam int unsigned NT = 14;
  localparam int unsigned CF = 100_000;
  localparam int unsigned DB = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NT-1:0] teclas = '0;
  logic          clk_out, activo;
  logic [IW-1:0] nota;
`ifdef OCTAVE_SHIFT_EN
  logic          bajar_octava = 1'b0;
`endif

  always #5 clk = ~clk;

  generador_tonos #(
    .NUM_TECLAS (NT),
    .CLK_FREQ   (CF),
    .DEBOUNCE   (DB),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .teclas       (teclas),
    .clk_out      (clk_out),
    .activo       (activo),
    .nota         (nota)
`ifdef OCTAVE_SHIFT_EN
    ,
    .bajar_octava (bajar_octava)
`endif
  );

  typedef struct {
    int nota;
    int half;
  } periodo_t;

  typedef struct {
    logic [NT-1:0] keys;
    int            nota;
    int            half;
    int            periodos;
  } vec_t;

  periodo_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int n, input int nt, input int h);
    periodo_t p;
    p.nota = nt;
    p.half = h;
    repeat (n) exp_q.push_back(p);
  endtask

  // Monitor: a period runs from a rising clk_out to the next rise or to activo falling.
  int mon_high, mon_low, mon_nota;
  bit in_period = 1'b0;

  task automatic cerrar_periodo();
    periodo_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_period: got nota %0d high %0d low %0d, expected none",
               mon_nota, mon_high, mon_low);
    end else begin
      e = exp_q.pop_front();
      check("period_nota", mon_nota, e.nota);
      check("period_high", mon_high, e.half);
      check("period_low", mon_low, e.half);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_period = 1'b0;
      end else if (clk_out) begin
        if (in_period && mon_low > 0) begin
          cerrar_periodo();
          in_period = 1'b0;
        end
        if (!in_period) begin
          in_period = 1'b1;
          mon_nota  = int'(nota);
          mon_high  = 0;
          mon_low   = 0;
        end
        mon_high++;
      end else if (in_period) begin
        if (!activo) begin
          cerrar_periodo();
          in_period = 1'b0;
        end else begin
          mon_low++;
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d periods pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_silencio(input string name, input int ncyc);
    int ok = 1;
    repeat (ncyc) begin
      @(negedge clk);
      if (clk_out || activo) ok = 0;
    end
    check(name, ok, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  vec_t tabla[7];
  int   prev_nota, prev_half, n;

  initial begin
    tabla[0] = '{keys: 14'h0003, nota: 0,  half: 47, periodos: 2};
    tabla[1] = '{keys: 14'h0002, nota: 1,  half: 42, periodos: 2};
    tabla[2] = '{keys: 14'h0080, nota: 7,  half: 23, periodos: 3};
    tabla[3] = '{keys: 14'h2000, nota: 13, half: 12, periodos: 3};
    tabla[4] = '{keys: 14'h0420, nota: 5,  half: 28, periodos: 2};
    tabla[5] = '{keys: 14'h0010, nota: 4,  half: 31, periodos: 2};
    tabla[6] = '{keys: 14'h0400, nota: 10, half: 17, periodos: 2};

    repeat (3) @(posedge clk);
    #1;
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_activo", int'(activo), 0);
    check("reset_nota", int'(nota), 0);
    @(negedge clk);
    reset = 1'b0;

    // Short glitch while idle must be ignored.
    teclas[3] = 1'b1;
    repeat (3) @(negedge clk);
    teclas[3] = 1'b0;
    check_silencio("glitch_quiet", 40);

    // Key 0 from idle: 2 sync + 4 debounce + 1 FSM cycles.
    push(2, 0, 47);
    teclas = 14'h0001;
    n = 0;
    while (!clk_out && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 7);
    check("activo_playing", int'(activo), 1);
    check("nota_playing", int'(nota), 0);
    wait_drain("key0");
    prev_nota = 0;
    prev_half = 47;

    // Each change lands mid-period: the running period completes, then the new note.
    for (int k = 0; k < 7; k++) begin
      push(1, prev_nota, prev_half);
      teclas = tabla[k].keys;
      push(tabla[k].periodos, tabla[k].nota, tabla[k].half);
      wait_drain("table");
      prev_nota = tabla[k].nota;
      prev_half = tabla[k].half;
    end

    // Release mid-high: period completes, then silence with nota held.
    push(1, prev_nota, prev_half);
    teclas = '0;
    wait_drain("release");
    check_silencio("release_quiet", 60);
    check("nota_hold", int'(nota), prev_nota);

    // Reset in the middle of a high half.
    push(2, 7, 23);
    teclas = 14'h0080;
    wait_drain("key7");
    @(posedge clk);
    #1;
    check("pre_reset_clk_out", int'(clk_out), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_clk_out", int'(clk_out), 0);
    check("midreset_activo", int'(activo), 0);
    check("midreset_nota", int'(nota), 0);
    teclas = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_silencio("post_reset_quiet", 20);
    push(2, 7, 23);
    teclas = 14'h0080;
    wait_drain("repress");
    push(1, 7, 23);
    teclas = '0;
    wait_drain("repress_release");
    check_silencio("repress_quiet", 30);

`ifdef OCTAVE_SHIFT_EN
    bajar_octava = 1'b1;
    push(2, 0, 94);
    teclas = 14'h0001;
    wait_drain("octava_baja");
    bajar_octava = 1'b0;
    push(1, 0, 94);
    push(2, 0, 47);
    wait_drain("octava_cambio");
    push(1, 0, 47);
    teclas = '0;
    wait_drain("octava_fin");
    check_silencio("octava_quiet", 30);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/generador_tonos.md
Name: generador_tonos

Overview:
Parametrised successor to the fixed 7-note music-box tone selector. It takes NUM_TECLAS key inputs and passes each through a synchroniser and debouncer. It picks the lowest-index pressed key and drives one shared half-period counter that produces a square wave. Note changes and key release take effect only at full-period boundaries, so the output never glitches. It sits between the keypad pins and the speaker/audio pin of the caja_musica top.

Parameters:
NUM_TECLAS, 7, number of keys (1..14); key i plays base note i%7 in octave i/7, where octave 1 is double frequency.
CLK_FREQ, 50_000_000, input clock frequency in Hz.
DEBOUNCE, 16, consecutive stable synchronised cycles required before a key state is accepted (>=1).
CNT_W, 16, half-period counter width; must hold 2*max half-period when OCTAVE_SHIFT_EN is defined.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
teclas  input  NUM_TECLAS  raw asynchronous key levels; 1 = pressed.
clk_out  output  1  square-wave tone output.
activo  output  1  high while a tone is playing.
nota  output  $clog2(NUM_TECLAS) (min 1)  index of the key currently sounding; holds its last value when idle.
bajar_octava  input  1  present only with OCTAVE_SHIFT_EN.

Behaviour:
- Reset (sampled at a rising clk edge): clk_out=0, activo=0, nota=0, state=IDLE, counter=0, all synchroniser and debouncer state cleared to "released". Reset mid-tone silences the output on that edge.
- Key path, per bit:
  - 2-flop synchroniser, then debouncer.
  - The debounced level changes only after the synchronised level has differed from it for DEBOUNCE consecutive cycles.
  - Pulses shorter than that are ignored.
- Request logic:
  - req_valid = OR of the debounced keys.
  - req_idx = lowest set index (priority encoder).
- Half-period table:
  - HALF[i] = (CLK_FREQ / (2*FREQ_NOTAS[i%7])) >> (i/7), using integer floor.
  - Computed at elaboration, not at run time.
- State IDLE:
  - clk_out=0, activo=0.
  - If req_valid: nota<=req_idx, counter<=HALF[req_idx]-1, clk_out<=1, activo<=1, go to PLAY.
  - Latency from debounced key to clk_out high is 1 cycle.
- State PLAY, counter!=0: counter decrements.
- State PLAY, counter==0 with clk_out=1: clk_out<=0, counter<=HALF[nota]-1.
- State PLAY, counter==0 with clk_out=0 (end of full period):
  - If req_valid: nota<=req_idx, reload from HALF[req_idx]-1, clk_out<=1. This is a seamless restart; a new note is adopted only here.
  - Else: go to IDLE, activo<=0.
- Output waveform:
  - Period is exactly 2*HALF[nota] cycles with a 50% duty cycle.
  - A key change or release mid-period never truncates the current period.
- Simultaneous presses resolve by priority at each period boundary. Changes between boundaries are invisible.
- Counter never wraps; it is always reloaded at 0.
- Elaboration error if any HALF value is 0 or exceeds 2^CNT_W-1.

Optional Feature:
- Macro: OCTAVE_SHIFT_EN.
- Defined:
  - Port bajar_octava exists.
  - Effective half-period = HALF[idx] << bajar_octava, i.e. one octave down.
  - bajar_octava is sampled only at full-period boundaries and at IDLE->PLAY; the value is latched with nota.
- Undefined: the port is absent and the half-period is always HALF[idx].

Decomposition:
- Package musica_pkg:
  - NUM_NOTAS_BASE=7.
  - FREQ_NOTAS[0:6] = {1046,1174,1318,1396,1567,1760,1975}.
  - State typedef {IDLE, PLAY}.
  - Half-period constant function.
- Sub-module antirrebote:
  - Per-key 2-flop synchroniser plus DEBOUNCE counter.
  - Parameter DEBOUNCE; ports clk, reset, entrada, salida.
  - Instantiated NUM_TECLAS times in a generate loop.

Test Plan:
Bench parameters: CLK_FREQ=100_000, DEBOUNCE=4, NUM_TECLAS=14. This gives HALF[0]=47, HALF[1]=42, HALF[7]=23.
1. Hold teclas[0]=1 -> clk_out rises 2+4+1 cycles after the input; square wave of 47 high / 47 low cycles; nota=0; activo=1.
2. Press teclas[0] and teclas[1] together -> nota=0 and period 94. Release key 0 mid-high-half -> the current 94-cycle period completes, then 42/42 with nota=1.
3. Release all keys mid-high-half -> the period completes, clk_out stays 0, activo falls at the period end; no runt pulse.
4. 3-cycle glitch on teclas[3] while idle -> clk_out stays 0 and activo stays 0.
5. teclas[7] held -> 23/23 waveform, nota=7. Assert reset mid-high -> next edge clk_out=0, activo=0, nota=0; after reset, a re-press restarts cleanly.
6. With OCTAVE_SHIFT_EN: teclas[0] held and bajar_octava=1 -> 94/94 waveform. Toggle bajar_octava mid-period -> the change applies only from the next period boundary.
